// File: rtl/counter_snapshot_fifo.sv
// Snapshot FIFO: captures the tick counter and its delta since the last accepted capture,
// drained over valid/ready. Captures that arrive while full are dropped and counted.
module counter_snapshot_fifo #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     snap_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [WIDTH-1:0]         out_delta,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_W-1:0]        drop_count,
    output logic                     overflow,
    input  logic                     clear_drops
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0]  data_mem  [DEPTH];
    logic [WIDTH-1:0]  delta_mem [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ovf_q, ovf_d;

    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;
    logic [WIDTH-1:0]  new_delta;

    assign full      = (level_q == LW'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign push_ok   = snap_req & (~full | pop);
    assign drop      = snap_req & full & ~pop;
    assign new_delta = count_in - last_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        last_d   = last_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            last_d   = count_in;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Clear takes effect first, so a drop in the same cycle still counts as one.
        if (clear_drops) begin
            drop_d = drop ? DROP_W'(1) : '0;
            ovf_d  = drop;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (!(&drop_q)) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            last_q   <= last_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left unreset; validity comes from level_q alone.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            data_mem[wr_ptr_q]  <= count_in;
            delta_mem[wr_ptr_q] <= new_delta;
        end
    end

    always_comb begin
        out_valid  = (level_q != '0);
        out_data   = out_valid ? data_mem[rd_ptr_q]  : '0;
        out_delta  = out_valid ? delta_mem[rd_ptr_q] : '0;
        level      = level_q;
        drop_count = drop_q;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_counter_snapshot_fifo.sv
// Scoreboard bench for counter_snapshot_fifo: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_counter_snapshot_fifo;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int DW = 2;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  count_in = '0;
    logic          snap_req = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [W-1:0]  out_delta;
    logic [$clog2(D):0] level;
    logic [DW-1:0] drop_count;
    logic          overflow;
    logic          clear_drops = 1'b0;

    counter_snapshot_fifo #(
        .WIDTH (W),
        .DEPTH (D),
        .DROP_W(DW)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .count_in   (count_in),
        .snap_req   (snap_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_delta  (out_delta),
        .level      (level),
        .drop_count (drop_count),
        .overflow   (overflow),
        .clear_drops(clear_drops)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: queued entries plus occupancy/drop state before and after the next edge.
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   last_cap = '0;
    int             cur_level = 0, nxt_level = 0;
    int             cur_drops = 0, nxt_drops = 0;
    bit             cur_ovf = 0, nxt_ovf = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        last_cap  = '0;
        cur_level = 0;
        nxt_level = 0;
        cur_drops = 0;
        nxt_drops = 0;
        cur_ovf   = 0;
        nxt_ovf   = 0;
    endfunction

    // Monitor: compares the DUT against the model on every falling edge.
    always @(negedge clock) begin
        logic [2*W-1:0] e;
        chk("out_valid", 64'(out_valid), 64'(cur_level != 0));
        chk("level", 64'(level), 64'(cur_level));
        chk("drop_count", 64'(drop_count), 64'(cur_drops));
        chk("overflow", 64'(overflow), 64'(cur_ovf));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL head_present: got valid entry expected empty queue at %0t", $time);
            end else begin
                e = exp_q[0];
                chk("head_data", 64'(out_data), 64'(e[2*W-1:W]));
                chk("head_delta", 64'(out_delta), 64'(e[W-1:0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            chk("idle_outputs", {out_data, out_delta}, 64'd0);
        end
    end

    // Apply one cycle of stimulus just after a rising edge and advance the model.
    task automatic step(input bit req, input logic [W-1:0] cnt, input bit rdy, input bit clr);
        bit pop, full, acc, drp;
        @(posedge clock);
        #1;
        cur_level = nxt_level;
        cur_drops = nxt_drops;
        cur_ovf   = nxt_ovf;
        snap_req    = req;
        count_in    = cnt;
        out_ready   = rdy;
        clear_drops = clr;
        if (!rst_n) begin
            model_clear();
            return;
        end
        pop  = (cur_level != 0) && rdy;
        full = (cur_level == D);
        acc  = req && (!full || pop);
        drp  = req && full && !pop;
        if (acc) begin
            exp_q.push_back({cnt, cnt - last_cap});
            last_cap = cnt;
        end
        nxt_level = cur_level + int'(acc) - int'(pop);
        if (clr) begin
            nxt_drops = drp ? 1 : 0;
            nxt_ovf   = drp;
        end else if (drp) begin
            nxt_ovf   = 1;
            nxt_drops = (cur_drops < DROP_MAX) ? cur_drops + 1 : cur_drops;
        end else begin
            nxt_drops = cur_drops;
            nxt_ovf   = cur_ovf;
        end
    endtask

    // Assert reset between clock edges and check it acts without a clock.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_level", 64'(level), 64'd0);
        snap_req    = 1'b0;
        out_ready   = 1'b0;
        clear_drops = 1'b0;
        model_clear();
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        #2;
        rst_n = 1'b1;
    endtask

    logic [W-1:0] rcnt;

    initial begin
        model_clear();
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_level", 64'(level), 64'd0);
        repeat (2) @(posedge clock);
        #3;
        rst_n = 1'b1;

        // Single capture after reset.
        step(1, 32'd100, 0, 0);
        step(0, '0, 0, 0);
        chk("t1_data", 64'(out_data), 64'd100);
        chk("t1_delta", 64'(out_delta), 64'd100);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        chk("t1_empty_data", 64'(out_data), 64'd0);

        // Wrapping deltas from a fresh reset.
        mid_reset();
        step(1, 32'hFFFF_FFF0, 0, 0);
        step(1, 32'hFFFF_FFFF, 0, 0);
        step(1, 32'h0000_0005, 0, 0);
        step(0, '0, 0, 0);
        chk("t2_level", 64'(level), 64'd3);
        chk("t2_first_delta", 64'(out_delta), 64'hFFFF_FFF0);
        repeat (3) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Fill to full and drop two captures.
        for (int i = 10; i <= 15; i++) step(1, W'(i), 0, 0);
        step(0, '0, 0, 0);
        chk("t3_level", 64'(level), 64'd4);
        chk("t3_drops", 64'(drop_count), 64'd2);
        chk("t3_ovf", 64'(overflow), 64'd1);
        step(0, '0, 1, 0);
        step(1, 32'd20, 0, 0);
        step(0, '0, 0, 0);

        // Full with simultaneous push and pop is not a drop.
        step(1, 32'd30, 1, 0);
        step(0, '0, 0, 0);
        chk("t4_level", 64'(level), 64'd4);
        chk("t4_drops", 64'(drop_count), 64'd2);

        // Saturation and clear behaviour.
        step(0, '0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, W'(40 + i), 0, 0);
        step(0, '0, 0, 0);
        chk("t5_sat", 64'(drop_count), 64'(DROP_MAX));
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        chk("t5_clear_drops", 64'(drop_count), 64'd0);
        chk("t5_clear_ovf", 64'(overflow), 64'd0);
        step(1, 32'd50, 0, 1);
        step(0, '0, 0, 0);
        chk("t5_clear_and_drop", 64'(drop_count), 64'd1);
        chk("t5_clear_and_drop_ovf", 64'(overflow), 64'd1);

        // Asynchronous reset mid-stream.
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        chk("t6_level_before", 64'(level), 64'd3);
        mid_reset();
        step(1, 32'd50, 0, 0);
        step(0, '0, 0, 0);
        chk("t6_delta", 64'(out_delta), 64'd50);
        step(0, '0, 1, 0);

        // Random traffic.
        rcnt = 32'hFFFF_FF00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) rcnt = $urandom;
            else rcnt = rcnt + W'($urandom_range(0, 7));
            if (i == 300) mid_reset();
            step(bit'($urandom_range(0, 1)), rcnt, bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 19) == 0));
        end

        repeat (D + 2) step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
